// File: rtl/mem_block_mover_pkg.sv
// Shared state encodings, mode constants and address helpers for the block mover.
package mem_block_mover_pkg;

   localparam int MBM_ADDR_WIDTH = 30;

   typedef enum logic [2:0] {
      MBM_IDLE  = 3'd0,
      MBM_REQ   = 3'd1,
      MBM_READ  = 3'd2,
      MBM_WRITE = 3'd3,
      MBM_DONE  = 3'd4
   } mbm_state_e;

   localparam logic MBM_COPY = 1'b0;
   localparam logic MBM_FILL = 1'b1;

   // Word addresses wrap naturally at the top of the 30-bit space.
   function automatic logic [MBM_ADDR_WIDTH-1:0] mbm_next_addr(
      input logic [MBM_ADDR_WIDTH-1:0] addr
   );
      return addr + MBM_ADDR_WIDTH'(1);
   endfunction

endpackage

// File: rtl/mem_block_mover.sv
// Bus-initiating copy/fill engine for the word-addressed single-port Memory bus.
// Control and status are registered; bus outputs follow state and the live grant.
module mem_block_mover
   import mem_block_mover_pkg::*;
#(
   parameter int DATA_BIT_WIDTH = 32,
   parameter int LEN_BIT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      mode,
   input  logic [MBM_ADDR_WIDTH-1:0] src,
   input  logic [MBM_ADDR_WIDTH-1:0] dst,
   input  logic [LEN_BIT_WIDTH-1:0]  len,
   input  logic [DATA_BIT_WIDTH-1:0] fill_value,
   output logic                      busy,
   output logic                      done,
   output logic                      bus_req,
   input  logic                      bus_gnt,
   output logic [MBM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_en_write,
   output logic [DATA_BIT_WIDTH-1:0] mem_wdata,
   input  logic [DATA_BIT_WIDTH-1:0] mem_rdata
);

   mbm_state_e                r_state;
   logic                      r_mode;
   logic [MBM_ADDR_WIDTH-1:0] r_src;
   logic [MBM_ADDR_WIDTH-1:0] r_dst;
   logic [LEN_BIT_WIDTH-1:0]  r_remain;
   logic [DATA_BIT_WIDTH-1:0] r_fill;
   logic [DATA_BIT_WIDTH-1:0] r_buf;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_busReq;

   logic w_readActive;
   logic w_writeActive;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= MBM_IDLE;
         r_mode   <= MBM_COPY;
         r_src    <= '0;
         r_dst    <= '0;
         r_remain <= '0;
         r_fill   <= '0;
         r_buf    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_busReq <= 1'b0;
      end else begin
         case (r_state)
            MBM_IDLE: begin
               if (start) begin
                  r_mode   <= mode;
                  r_src    <= src;
                  r_dst    <= dst;
                  r_remain <= len;
                  r_fill   <= fill_value;
                  r_busy   <= 1'b1;
                  if (len == '0) begin
                     r_state <= MBM_DONE;
                  end else begin
                     r_state  <= MBM_REQ;
                     r_busReq <= 1'b1;
                  end
               end
            end

            MBM_REQ: begin
               if (bus_gnt) begin
                  r_state <= (r_mode == MBM_FILL) ? MBM_WRITE : MBM_READ;
               end
            end

            MBM_READ: begin
               if (bus_gnt) begin
                  r_buf   <= mem_rdata;
                  r_state <= MBM_WRITE;
               end
            end

            MBM_WRITE: begin
               if (bus_gnt) begin
                  r_src    <= mbm_next_addr(r_src);
                  r_dst    <= mbm_next_addr(r_dst);
                  r_remain <= r_remain - LEN_BIT_WIDTH'(1);
                  if (r_remain == LEN_BIT_WIDTH'(1)) begin
                     r_state  <= MBM_DONE;
                     r_busReq <= 1'b0;
                     r_done   <= 1'b1;
                  end else if (r_mode == MBM_COPY) begin
                     r_state <= MBM_READ;
                  end
               end
            end

            // A zero-length command arrives here with done still low, so it
            // spends one extra cycle raising the pulse before returning to idle.
            MBM_DONE: begin
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= MBM_IDLE;
               end else begin
                  r_done <= 1'b1;
               end
            end

            default: begin
               r_state  <= MBM_IDLE;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_busReq <= 1'b0;
            end
         endcase
      end
   end

   assign w_readActive  = (r_state == MBM_READ)  && bus_gnt;
   assign w_writeActive = (r_state == MBM_WRITE) && bus_gnt;

   // The bus is only driven while granted; otherwise it sits at the idle value.
   always_comb begin
      mem_addr     = '0;
      mem_en_write = 1'b0;
      mem_wdata    = '0;
      if (w_readActive) begin
         mem_addr = r_src;
      end else if (w_writeActive) begin
         mem_addr     = r_dst;
         mem_en_write = 1'b1;
         mem_wdata    = (r_mode == MBM_FILL) ? r_fill : r_buf;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bus_req = r_busReq;

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover: table-driven transfers against a
// small memory model, with a write scoreboard and hand-written corner sequences.
module tb_mem_block_mover;
   import mem_block_mover_pkg::*;

   localparam logic [29:0] TB_LEDR = 30'h3000_0100;

   typedef struct {
      logic        mode;
      logic [29:0] src;
      logic [29:0] dst;
      int          len;
      logic [31:0] fill;
      int          expLat;
   } vec_t;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic [29:0] src;
   logic [29:0] dst;
   logic [15:0] len;
   logic [31:0] fill_value;
   logic        busy;
   logic        done;
   logic        bus_req;
   logic        bus_gnt;
   logic [29:0] mem_addr;
   logic        mem_en_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] arr [1024];
   logic [31:0] ledr;
   wr_t         expQ[$];
   int          checks;
   int          errors;
   int          writeCount;
   logic        sawReq;
   logic        prevWr;
   logic        tbMode;

   mem_block_mover #(
      .DATA_BIT_WIDTH(32),
      .LEN_BIT_WIDTH (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .fill_value  (fill_value),
      .busy        (busy),
      .done        (done),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .mem_addr    (mem_addr),
      .mem_en_write(mem_en_write),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on rising edge, LEDR as MMIO.
   assign mem_rdata = arr[mem_addr[9:0]];

   always @(posedge clk) begin
      if (mem_en_write) begin
         if (mem_addr == TB_LEDR) ledr <= mem_wdata;
         else arr[mem_addr[9:0]] <= mem_wdata;
      end
   end

   function automatic logic [31:0] pattern(input logic [29:0] a);
      return 32'hA500_0000 | {22'h0, a[9:0]};
   endfunction

   // Bus monitor: pops the scoreboard on every write and watches grant rules.
   always @(negedge clk) begin
      if (bus_req) sawReq = 1'b1;
      if (mem_en_write) begin
         writeCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write actual=%h/%h required=none", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = expQ.pop_front();
            if (w.addr != mem_addr || w.data != mem_wdata) begin
               errors++;
               $display("[TB] FAIL write_sb actual=%h/%h required=%h/%h", mem_addr, mem_wdata, w.addr, w.data);
            end
         end
         if (tbMode == MBM_COPY && prevWr) begin
            checks++;
            errors++;
            $display("[TB] FAIL consecutive_write actual=1 required=0");
         end
      end
      if (!bus_gnt) begin
         checks++;
         if (mem_en_write || mem_addr != '0) begin
            errors++;
            $display("[TB] FAIL idle_bus_no_gnt actual=%b/%h required=0/0", mem_en_write, mem_addr);
         end
      end
      prevWr = mem_en_write;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < 1024; i++) arr[i] = pattern(30'(i));
      ledr = '0;
   endtask

   // Drives one command pulse and queues the writes it must produce.
   task automatic applyStimulus(input vec_t v);
      wr_t w;
      tbMode = v.mode;
      for (int i = 0; i < v.len; i++) begin
         w.addr = v.dst + 30'(i);
         w.data = (v.mode == MBM_FILL) ? v.fill : pattern(v.src + 30'(i));
         expQ.push_back(w);
      end
      writeCount = 0;
      sawReq     = 1'b0;
      start      = 1'b1;
      mode       = v.mode;
      src        = v.src;
      dst        = v.dst;
      len        = 16'(v.len);
      fill_value = v.fill;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input int startCyc, input int limit, output int lat);
      lat = startCyc;
      while (!done && lat < limit) begin
         tick();
         lat++;
      end
   endtask

   task automatic runVector(input string name, input vec_t v);
      int lat;
      logic [29:0] a;
      preload();
      applyStimulus(v);
      checkOutput({name, "_busy"}, 64'(busy), 64'(1));
      waitDone(1, 60, lat);
      checkOutput({name, "_latency"}, 64'(lat), 64'(v.expLat));
      tick();
      checkOutput({name, "_done_pulse"}, 64'(done), 64'(0));
      checkOutput({name, "_busy_end"}, 64'(busy), 64'(0));
      checkOutput({name, "_pending"}, 64'(expQ.size()), 64'(0));
      for (int i = 0; i < v.len; i++) begin
         a = v.dst + 30'(i);
         checkOutput({name, "_dst"}, 64'(arr[a[9:0]]),
                     64'((v.mode == MBM_FILL) ? v.fill : pattern(v.src + 30'(i))));
      end
      a = v.dst + 30'(v.len);
      checkOutput({name, "_after_dst"}, 64'(arr[a[9:0]]), 64'(pattern(a)));
      if (v.mode == MBM_COPY && v.len > 0)
         checkOutput({name, "_src_kept"}, 64'(arr[v.src[9:0]]), 64'(pattern(v.src)));
      if (v.len == 0) begin
         checkOutput({name, "_no_req"}, 64'(sawReq), 64'(0));
         checkOutput({name, "_no_writes"}, 64'(writeCount), 64'(0));
      end
      expQ.delete();
   endtask

   vec_t vecs[7];

   initial begin
      int   lat;
      int   lowLeft;
      logic dropped;
      vec_t v;

      checks = 0;
      errors = 0;
      prevWr = 1'b0;
      tbMode = MBM_COPY;
      sawReq = 1'b0;
      writeCount = 0;
      reset = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      src = '0;
      dst = '0;
      len = '0;
      fill_value = '0;
      bus_gnt = 1'b1;
      preload();

      vecs[0] = '{MBM_COPY, 30'h10,        30'h40,        4, 32'h0,         10};
      vecs[1] = '{MBM_FILL, 30'h0,         30'h100,       3, 32'hDEADBEEF,  5};
      vecs[2] = '{MBM_COPY, 30'h20,        30'h80,        1, 32'h0,         4};
      vecs[3] = '{MBM_FILL, 30'h0,         30'h150,       0, 32'h55AA55AA,  2};
      vecs[4] = '{MBM_COPY, 30'h3FFFFFFE,  30'h200,       3, 32'h0,         8};
      vecs[5] = '{MBM_FILL, 30'h0,         30'h3FFFFFFF,  2, 32'h12345678,  4};
      vecs[6] = '{MBM_COPY, 30'h30,        30'h60,        0, 32'h0,         2};

      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_done", 64'(done), 64'(0));
      checkOutput("reset_req", 64'(bus_req), 64'(0));
      checkOutput("reset_wen", 64'(mem_en_write), 64'(0));
      checkOutput("reset_addr", 64'(mem_addr), 64'(0));
      checkOutput("reset_wdata", 64'(mem_wdata), 64'(0));

      for (int i = 0; i < 7; i++) begin
         runVector($sformatf("vec%0d", i), vecs[i]);
         tick();
      end

      // Fill into the LEDR MMIO register.
      preload();
      v = '{MBM_FILL, 30'h0, TB_LEDR, 1, 32'h3FF, 3};
      applyStimulus(v);
      waitDone(1, 40, lat);
      checkOutput("ledr_latency", 64'(lat), 64'(3));
      tick();
      checkOutput("ledr_value", 64'(ledr), 64'(32'h3FF));
      expQ.delete();
      tick();

      // Grant withdrawn for three cycles right after the second write.
      preload();
      v = vecs[0];
      applyStimulus(v);
      lat = 1;
      lowLeft = 0;
      dropped = 1'b0;
      while (!done && lat < 60) begin
         if (!dropped && writeCount == 2) begin
            bus_gnt = 1'b0;
            lowLeft = 3;
            dropped = 1'b1;
         end
         tick();
         lat++;
         if (lowLeft > 0) begin
            lowLeft--;
            if (lowLeft == 0) bus_gnt = 1'b1;
         end
      end
      bus_gnt = 1'b1;
      checkOutput("gnt_drop_latency", 64'(lat), 64'(13));
      tick();
      for (int i = 0; i < 4; i++)
         checkOutput("gnt_drop_dst", 64'(arr[10'h40 + 10'(i)]), 64'(pattern(30'h10 + 30'(i))));
      checkOutput("gnt_drop_pending", 64'(expQ.size()), 64'(0));
      expQ.delete();
      tick();

      // A second start while busy must not disturb the running copy.
      preload();
      applyStimulus(vecs[0]);
      tick();
      tick();
      start = 1'b1;
      mode = MBM_FILL;
      dst = 30'h300;
      len = 16'd2;
      fill_value = 32'hCAFEF00D;
      tick();
      start = 1'b0;
      waitDone(4, 60, lat);
      checkOutput("busy_start_latency", 64'(lat), 64'(10));
      tick();
      checkOutput("busy_start_untouched", 64'(arr[10'h300]), 64'(pattern(30'h300)));
      checkOutput("busy_start_dst", 64'(arr[10'h43]), 64'(pattern(30'h13)));
      checkOutput("busy_start_pending", 64'(expQ.size()), 64'(0));
      expQ.delete();
      tick();

      // Reset in the middle of an eight-word copy.
      preload();
      v = '{MBM_COPY, 30'h10, 30'h40, 8, 32'h0, 18};
      applyStimulus(v);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      checkOutput("midrst_done", 64'(done), 64'(0));
      checkOutput("midrst_req", 64'(bus_req), 64'(0));
      checkOutput("midrst_wen", 64'(mem_en_write), 64'(0));
      checkOutput("midrst_addr", 64'(mem_addr), 64'(0));
      checkOutput("midrst_wdata", 64'(mem_wdata), 64'(0));
      reset = 1'b0;
      expQ.delete();
      tick();
      runVector("after_reset", vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
